mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath, alongside the alu; consumes the reg_file read_data1/read_data2 operands (rs, rt).
- Executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers, which the writeback mux reads for MFHI/MFLO.
- Sequential shift-add multiply and restoring divide, one bit per cycle.
- Raises busy so the controller stalls pc/pipeline until the result is committed.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  launch operation; accepted only when busy=0
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
rs_data  input  WIDTH  operand A (multiplicand / dividend)
rt_data  input  WIDTH  operand B (multiplier / divisor)
flush  input  1  abort the in-flight operation; HI/LO unchanged
hi_we  input  1  MTHI: load hi from wdata
lo_we  input  1  MTLO: load lo from wdata
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in flight
done  output  1  one-cycle pulse: HI/LO just updated
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rst=0, async): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators=0. Reset mid-operation abandons the operation; no done pulse.
- States:
  - IDLE: start=1 at edge E0 latches op, |rs|/|rt| (signed ops) or raw values (unsigned ops), and the result-sign flags; next state RUN, busy=1 from E0.
  - RUN: one iteration per cycle, exactly WIDTH iterations (edges E1..E32). Multiply: 2*WIDTH-bit shift-add. Divide: restoring shift/subtract, one quotient bit per cycle.
  - FIX: at edge E33 applies sign correction, writes hi/lo, busy=0, done=1 for the following cycle only; next state IDLE.
- Total latency: start edge to HI/LO valid = WIDTH+1 edges (33). A back-to-back start is accepted at the first edge where busy=0, i.e. the done cycle.
- Multiply result: {hi,lo} = full 64-bit product. Signed: two's-complement negate when the operand signs differ.
- Divide result: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Divide by zero (rt=0, either signedness): lo=32'hFFFF_FFFF, hi=rs_data as latched (signed: original signed value). Same 33-cycle latency.
- Signed overflow: DIV 32'h8000_0000 / 32'hFFFF_FFFF gives lo=32'h8000_0000, hi=0.
- start while busy=1: ignored; operands are not re-latched.
- flush=1: any state goes to IDLE at the next edge; busy=0, done stays 0, hi/lo unchanged. flush has priority over start in the same cycle.
- hi_we/lo_we: honoured only in IDLE with start=0; take effect at the next edge. When asserted together with start, start wins and the write is dropped. Ignored while busy.
- done never asserts except out of FIX. busy is purely a state decode (no combinational path from start).

Test Plan:
- Reset: rst=0 mid-RUN after a MULT start -> hi=0, lo=0, busy=0 immediately; no done pulse after release.
- MULTU: rs=32'hFFFF_FFFF, rt=32'h0000_0002, start one cycle -> busy=1 for 33 cycles; done pulse; hi=32'h0000_0001, lo=32'hFFFF_FFFE.
- MULT signed: rs=-7 (32'hFFFF_FFF9), rt=6 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFD6 (-42).
- DIV signed: rs=-7, rt=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIVU: rs=100, rt=7 -> lo=14, hi=2.
- Boundaries: DIVU rs=5, rt=0 -> lo=32'hFFFF_FFFF, hi=5. DIV 32'h8000_0000 / -1 -> lo=32'h8000_0000, hi=0.
- Control collisions:
  - flush at cycle 10 of a DIV -> busy=0 next cycle, hi/lo keep their prior values.
  - start while busy -> ignored.
  - hi_we + start together -> hi is the product, not wdata.
  - lo_we=1, wdata=32'h1234 in IDLE -> lo=32'h1234 next cycle.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Operand, control and result bundle between the pipeline controller and the
// iterative multiply/divide unit (HI/LO owner).
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs_data;
   logic [WIDTH-1:0] rt_data;
   logic             flush;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, rs_data, rt_data, flush, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, rs_data, rt_data, flush, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one bit per cycle on operand magnitudes,
// sign fix-up in a final cycle, results committed to the architectural HI/LO.
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic           clk,
   input  logic           rst,
   mult_div_unit_if.slave bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               isDiv_q, isDiv_d;
   logic               negRes_q, negRes_d;
   logic               negRem_q, negRem_d;
   logic               divZero_q, divZero_d;
   logic [WIDTH-1:0]   origRs_q, origRs_d;
   logic [WIDTH-1:0]   opB_q, opB_d;
   logic [2*WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic               signedOp;
   logic               rsNeg;
   logic               rtNeg;
   logic [WIDTH-1:0]   absRs;
   logic [WIDTH-1:0]   absRt;

   logic [WIDTH:0]     mulSum;
   logic [2*WIDTH:0]   mulStep;
   logic [2*WIDTH:0]   divShift;
   logic [WIDTH:0]     divTrial;
   logic               divFits;
   logic [2*WIDTH:0]   divStep;

   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] prodFix;
   logic [WIDTH-1:0]   quoFix;
   logic [WIDTH-1:0]   remFix;

   assign signedOp = ~bus.op[0];
   assign rsNeg    = signedOp & bus.rs_data[WIDTH-1];
   assign rtNeg    = signedOp & bus.rt_data[WIDTH-1];
   assign absRs    = rsNeg ? -bus.rs_data : bus.rs_data;
   assign absRt    = rtNeg ? -bus.rt_data : bus.rt_data;

   // Multiply: {acc upper, multiplier} shifts right, adding the multiplicand on a 1 bit.
   assign mulSum  = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opB_q} : '0);
   assign mulStep = {mulSum, acc_q[WIDTH-1:0]} >> 1;

   // Divide: {remainder, dividend/quotient} shifts left, keeping the trial subtract if it fits.
   assign divShift = {acc_q[2*WIDTH-1:0], 1'b0};
   assign divTrial = divShift[2*WIDTH:WIDTH] - {1'b0, opB_q};
   assign divFits  = divShift[2*WIDTH:WIDTH] >= {1'b0, opB_q};
   assign divStep  = divFits ? {divTrial, divShift[WIDTH-1:1], 1'b1} : divShift;

   assign product = acc_q[2*WIDTH-1:0];
   assign prodFix = negRes_q ? -product : product;
   assign quoFix  = negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign remFix  = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      isDiv_d   = isDiv_q;
      negRes_d  = negRes_q;
      negRem_d  = negRem_q;
      divZero_d = divZero_q;
      origRs_d  = origRs_q;
      opB_d     = opB_q;
      acc_d     = acc_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;

      if (bus.flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_d   = RUN;
                  cnt_d     = '0;
                  isDiv_d   = bus.op[1];
                  negRes_d  = rsNeg ^ rtNeg;
                  negRem_d  = rsNeg;
                  divZero_d = (bus.rt_data == '0);
                  origRs_d  = bus.rs_data;
                  if (bus.op[1]) begin
                     opB_d = absRt;
                     acc_d = {{(WIDTH+1){1'b0}}, absRs};
                  end else begin
                     opB_d = absRs;
                     acc_d = {{(WIDTH+1){1'b0}}, absRt};
                  end
               end else begin
                  if (bus.hi_we) hi_d = bus.wdata;
                  if (bus.lo_we) lo_d = bus.wdata;
               end
            end
            RUN: begin
               acc_d = isDiv_q ? divStep : mulStep;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_ITER) state_d = FIX;
            end
            FIX: begin
               state_d = IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
               if (!isDiv_q) begin
                  hi_d = prodFix[2*WIDTH-1:WIDTH];
                  lo_d = prodFix[WIDTH-1:0];
               end else if (divZero_q) begin
                  hi_d = origRs_q;
                  lo_d = '1;
               end else begin
                  hi_d = remFix;
                  lo_d = quoFix;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         isDiv_q   <= 1'b0;
         negRes_q  <= 1'b0;
         negRem_q  <= 1'b0;
         divZero_q <= 1'b0;
         origRs_q  <= '0;
         opB_q     <= '0;
         acc_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         isDiv_q   <= isDiv_d;
         negRes_q  <= negRes_d;
         negRem_q  <= negRem_d;
         divZero_q <= divZero_d;
         origRs_q  <= origRs_d;
         opB_q     <= opB_d;
         acc_q     <= acc_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic results, latency, boundaries
// and control collisions against hand-computed expectations.
module tb_mult_div_unit;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   mult_div_unit_if #(.WIDTH(32)) bus ();

   mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      bus.start   = 1'b1;
      bus.op      = o;
      bus.rs_data = a;
      bus.rt_data = b;
      tick();
      bus.start   = 1'b0;
   endtask

   // Cycles from the accepting edge until done is seen; also counts cycles busy dropped early.
   task automatic waitDone(output int cycles, output int busyDrops);
      cycles    = 0;
      busyDrops = 0;
      while (bus.done !== 1'b1 && cycles < 40) begin
         if (bus.busy !== 1'b1) busyDrops++;
         tick();
         cycles++;
      end
   endtask

   task automatic test_reset;
      total++;
      if ({bus.busy, bus.done} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL reset_flags busy/done got %b want 00", {bus.busy, bus.done});
      end
      total++;
      if ({bus.hi, bus.lo} !== 64'h0) begin
         bad++;
         $display("[TB] FAIL reset_hilo got %h want 0", {bus.hi, bus.lo});
      end
   endtask

   task automatic test_multu;
      int cyc, drops;
      launch(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
      waitDone(cyc, drops);
      total++;
      if (cyc !== 33 || drops !== 0) begin
         bad++;
         $display("[TB] FAIL multu_latency cycles=%0d drops=%0d want 33/0", cyc, drops);
      end
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL multu_busy_at_done got %b want 0", bus.busy);
      end
      total++;
      if (bus.hi !== 32'h0000_0001 || bus.lo !== 32'hFFFF_FFFE) begin
         bad++;
         $display("[TB] FAIL multu_result got %h_%h want 00000001_fffffffe", bus.hi, bus.lo);
      end
      tick();
      total++;
      if (bus.done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL done_pulse_width got %b want 0", bus.done);
      end
   endtask

   task automatic test_mult_signed;
      int cyc, drops;
      launch(OP_MULT, 32'hFFFF_FFF9, 32'h0000_0006);
      waitDone(cyc, drops);
      total++;
      if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFD6 || cyc !== 33) begin
         bad++;
         $display("[TB] FAIL mult_signed got %h_%h cyc=%0d want ffffffff_ffffffd6 cyc=33", bus.hi, bus.lo, cyc);
      end
   endtask

   task automatic test_divide;
      int cyc, drops;
      launch(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
      waitDone(cyc, drops);
      total++;
      if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD || cyc !== 33) begin
         bad++;
         $display("[TB] FAIL div_signed got hi=%h lo=%h cyc=%0d want hi=ffffffff lo=fffffffd cyc=33", bus.hi, bus.lo, cyc);
      end
      launch(OP_DIVU, 32'd100, 32'd7);
      waitDone(cyc, drops);
      total++;
      if (bus.hi !== 32'd2 || bus.lo !== 32'd14) begin
         bad++;
         $display("[TB] FAIL divu got hi=%0d lo=%0d want hi=2 lo=14", bus.hi, bus.lo);
      end
   endtask

   task automatic test_boundaries;
      int cyc, drops;
      launch(OP_DIVU, 32'd5, 32'd0);
      waitDone(cyc, drops);
      total++;
      if (bus.hi !== 32'd5 || bus.lo !== 32'hFFFF_FFFF || cyc !== 33) begin
         bad++;
         $display("[TB] FAIL divu_by_zero got hi=%h lo=%h cyc=%0d want hi=00000005 lo=ffffffff cyc=33", bus.hi, bus.lo, cyc);
      end
      launch(OP_DIV, 32'hFFFF_FFF9, 32'd0);
      waitDone(cyc, drops);
      total++;
      if (bus.hi !== 32'hFFFF_FFF9 || bus.lo !== 32'hFFFF_FFFF) begin
         bad++;
         $display("[TB] FAIL div_by_zero got hi=%h lo=%h want hi=fffffff9 lo=ffffffff", bus.hi, bus.lo);
      end
      launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      waitDone(cyc, drops);
      total++;
      if (bus.hi !== 32'h0 || bus.lo !== 32'h8000_0000) begin
         bad++;
         $display("[TB] FAIL div_overflow got hi=%h lo=%h want hi=00000000 lo=80000000", bus.hi, bus.lo);
      end
   endtask

   task automatic test_flush;
      int cyc, drops;
      bus.hi_we = 1'b1;
      bus.wdata = 32'hAAAA_5555;
      tick();
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b1;
      bus.wdata = 32'h1234_5678;
      tick();
      bus.lo_we = 1'b0;
      total++;
      if (bus.hi !== 32'hAAAA_5555 || bus.lo !== 32'h1234_5678) begin
         bad++;
         $display("[TB] FAIL mthi_mtlo got %h_%h want aaaa5555_12345678", bus.hi, bus.lo);
      end
      launch(OP_DIV, 32'd100, 32'd7);
      repeat (9) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      total++;
      if (bus.busy !== 1'b0 || bus.hi !== 32'hAAAA_5555 || bus.lo !== 32'h1234_5678) begin
         bad++;
         $display("[TB] FAIL flush got busy=%b hi=%h lo=%h want busy=0 hi=aaaa5555 lo=12345678", bus.busy, bus.hi, bus.lo);
      end
      waitDone(cyc, drops);
      total++;
      if (cyc !== 40) begin
         bad++;
         $display("[TB] FAIL flush_no_done done seen after %0d cycles want none", cyc);
      end
   endtask

   task automatic test_collisions;
      int cyc, drops;
      launch(OP_MULTU, 32'd3, 32'd4);
      repeat (4) tick();
      bus.start   = 1'b1;
      bus.op      = OP_MULTU;
      bus.rs_data = 32'd100;
      bus.rt_data = 32'd100;
      bus.hi_we   = 1'b1;
      bus.wdata   = 32'hDEAD_BEEF;
      tick();
      bus.start   = 1'b0;
      bus.hi_we   = 1'b0;
      total++;
      if (bus.hi !== 32'hAAAA_5555) begin
         bad++;
         $display("[TB] FAIL hi_we_while_busy got %h want aaaa5555", bus.hi);
      end
      waitDone(cyc, drops);
      total++;
      if (bus.hi !== 32'd0 || bus.lo !== 32'd12 || cyc !== 28) begin
         bad++;
         $display("[TB] FAIL start_while_busy got %h_%h cyc=%0d want 00000000_0000000c cyc=28", bus.hi, bus.lo, cyc);
      end
      bus.hi_we = 1'b1;
      bus.wdata = 32'hDEAD_BEEF;
      launch(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
      bus.hi_we = 1'b0;
      waitDone(cyc, drops);
      total++;
      if (bus.hi !== 32'd1 || bus.lo !== 32'd0) begin
         bad++;
         $display("[TB] FAIL hi_we_with_start got %h_%h want 00000001_00000000", bus.hi, bus.lo);
      end
      tick();
      bus.lo_we = 1'b1;
      bus.wdata = 32'h0000_1234;
      tick();
      bus.lo_we = 1'b0;
      total++;
      if (bus.lo !== 32'h0000_1234 || bus.hi !== 32'd1) begin
         bad++;
         $display("[TB] FAIL mtlo got hi=%h lo=%h want hi=00000001 lo=00001234", bus.hi, bus.lo);
      end
   endtask

   task automatic test_back_to_back;
      int cyc, drops;
      launch(OP_MULTU, 32'd9, 32'd9);
      waitDone(cyc, drops);
      launch(OP_DIVU, 32'd81, 32'd4);
      total++;
      if (bus.busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL back_to_back_accept busy=%b want 1", bus.busy);
      end
      waitDone(cyc, drops);
      total++;
      if (bus.hi !== 32'd1 || bus.lo !== 32'd20 || cyc !== 33) begin
         bad++;
         $display("[TB] FAIL back_to_back got hi=%0d lo=%0d cyc=%0d want hi=1 lo=20 cyc=33", bus.hi, bus.lo, cyc);
      end
   endtask

   task automatic test_reset_mid_run;
      int cyc, drops;
      launch(OP_MULT, 32'd1000, 32'd1000);
      repeat (5) tick();
      rst = 1'b0;
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         bad++;
         $display("[TB] FAIL reset_mid_run got busy=%b hi=%h lo=%h want 0/0/0", bus.busy, bus.hi, bus.lo);
      end
      tick();
      tick();
      rst = 1'b1;
      waitDone(cyc, drops);
      total++;
      if (cyc !== 40) begin
         bad++;
         $display("[TB] FAIL reset_no_done done seen after %0d cycles want none", cyc);
      end
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      rst         = 1'b0;
      bus.start   = 1'b0;
      bus.op      = 2'b00;
      bus.rs_data = '0;
      bus.rt_data = '0;
      bus.flush   = 1'b0;
      bus.hi_we   = 1'b0;
      bus.lo_we   = 1'b0;
      bus.wdata   = '0;
      #12;
      test_reset();
      rst = 1'b1;
      tick();
      test_multu();
      test_mult_signed();
      test_divide();
      test_boundaries();
      test_flush();
      test_collisions();
      test_back_to_back();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
